bt2_tx_queue: RTL and testbench

//   Byte FIFO and send sequencer directly upstream of the PMOD BT2 UART block.
//   - User logic pushes bytes at any rate, up to DEPTH outstanding.
//   - The block drains them one at a time over the UART's send/sent handshake.
//   - One byte is presented per transfer; send is held until sent, then dropped

---
 rtl/bt2_tx_queue_pkg.sv | 16 +
 rtl/bt2_tx_queue_if.sv | 31 +++
 rtl/bt2_fifo_mem.sv | 25 ++
 rtl/bt2_tx_queue.sv | 126 ++++++++++++
 tb/tb_bt2_tx_queue.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bt2_tx_queue_pkg.sv
// Purpose : shared types and default sizing for the BT2 TX queue.
// Latency : n/a (types and constants only).
// Backpres: n/a.
package bt2_tx_queue_pkg;

    // Default sizing, also used by the RX-side block.
    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = 4;

    // Send sequencer states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/bt2_tx_queue_if.sv
// Purpose : byte-push and UART send/sent signals of the BT2 TX queue in one bundle.
// Latency : n/a (wires only).
// Backpres: full/overflow on the push side; the send/sent handshake on the UART side.
// Ports   : slave = queue side, master = user logic plus UART side.
interface bt2_tx_queue_if
    import bt2_tx_queue_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [ADDR_W:0] count;
    logic          overflow;
    logic          clr_overflow;
    logic          busy;
    logic [7:0]    char_in;
    logic          send;
    logic          sent;

    modport slave (
        input  wr_data, wr_en, clr_overflow, sent,
        output full, empty, count, overflow, busy, char_in, send
    );

    modport master (
        output wr_data, wr_en, clr_overflow, sent,
        input  full, empty, count, overflow, busy, char_in, send
    );
endinterface

// File: rtl/bt2_fifo_mem.sv
// Purpose : DEPTH x 8 byte storage for the TX queue; contents are not reset.
// Latency : write lands on the clock edge; read is combinational from rd_addr.
// Backpres: none; the caller only writes when the queue has room.
// Ports   : clk, wr_en/wr_addr/wr_data (sync write), rd_addr -> rd_data (async read).
module bt2_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/bt2_tx_queue.sv
// Purpose : byte FIFO feeding the PMOD BT2 UART one byte per send/sent handshake.
// Latency : write at edge N into an idle empty queue -> send=1 after edge N+1.
// Backpres: writes at full are dropped and flag sticky overflow; pops wait for sent=0.
// Ports   : clk, rst_n (async active-low), bus (bt2_tx_queue_if.slave).
module bt2_tx_queue
    import bt2_tx_queue_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    bt2_tx_queue_if.slave bus
);
    localparam int CNT_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        char_q, char_d;
    logic [7:0]        rd_data;
    logic              wr_acc;
    logic              wr_drop;
    logic              pop;

    bt2_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    always_comb begin
        // Registered full gates the write, so a pop in the same cycle does
        // not make room for it.
        wr_acc   = bus.wr_en && !full_q;
        wr_drop  = bus.wr_en && full_q;
        pop      = 1'b0;
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        char_d   = char_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                // The !sent guard waits for the UART to finish clearing sent
                // from the previous byte, so no byte is handed over twice.
                if (!empty_q && !bus.sent) begin
                    pop      = 1'b1;
                    char_d   = rd_data;
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.sent) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        case ({wr_acc, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Pointers wrap silently; the count tells full apart from empty.
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);

        // A drop in the same cycle as a clear keeps the flag set.
        if (wr_drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            char_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            char_q   <= char_d;
        end
    end

    // send and busy both mean "a byte is in flight".
    assign bus.send     = (state_q == ST_SEND);
    assign bus.busy     = (state_q == ST_SEND);
    assign bus.char_in  = char_q;
    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bt2_tx_queue.sv
// Purpose : self-checking bench for bt2_tx_queue with a queue-based reference model.
// Latency : n/a.
// Backpres: UART side modelled as a registered responder (sent rises 5 cycles after send).
module tb_bt2_tx_queue;
    import bt2_tx_queue_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bt2_tx_queue_if #(.ADDR_W(ADDR_W_DEF)) ifc ();

    bt2_tx_queue #(
        .DEPTH  (DEPTH_DEF),
        .ADDR_W (ADDR_W_DEF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [7:0] mq[$];
    logic       m_send = 1'b0;
    logic       m_ov   = 1'b0;
    logic [7:0] m_char = 8'h00;

    // Observation log.
    logic [7:0] seen[$];
    int         dut_rises     = 0;
    logic       prev_send_obs = 1'b0;

    // UART model: registered, reacts to send one edge late; uart_force pins sent high.
    logic uart_force = 1'b0;
    int   u_cnt      = 0;
    logic u_prev     = 1'b0;

    initial begin
        ifc.sent = 1'b0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                u_cnt    = 0;
                u_prev   = 1'b0;
                ifc.sent = 1'b0;
            end else begin
                if (u_prev) u_cnt++;
                else        u_cnt = 0;
                ifc.sent = uart_force || (u_prev && (u_cnt >= 5));
                u_prev   = ifc.send;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the rules, compare everything.
    task automatic step(input logic we, input logic [7:0] d, input logic clr);
        int   n_pre;
        logic sent_e;
        logic exp_send;
        ifc.wr_en        = we;
        ifc.wr_data      = d;
        ifc.clr_overflow = clr;
        n_pre = mq.size();
        @(posedge clk);
        #2;
        sent_e   = ifc.sent;
        exp_send = m_send ? !sent_e : ((n_pre > 0) && !sent_e);
        if (!m_send && exp_send) m_char = mq.pop_front();
        if (we) begin
            if (n_pre < DEPTH_DEF) mq.push_back(d);
            else                   m_ov = 1'b1;
        end
        if (clr && !(we && (n_pre >= DEPTH_DEF))) m_ov = 1'b0;
        m_send = exp_send;

        if (ifc.send && !prev_send_obs) begin
            dut_rises++;
            seen.push_back(ifc.char_in);
        end
        prev_send_obs = ifc.send;

        chk("send", ifc.send, m_send);
        chk("busy", ifc.busy, m_send);
        if (m_send) chk("char_in", ifc.char_in, m_char);
        chk("count", ifc.count, mq.size());
        chk("empty", ifc.empty, mq.size() == 0);
        chk("full", ifc.full, mq.size() == DEPTH_DEF);
        chk("overflow", ifc.overflow, m_ov);
        ifc.wr_en        = 1'b0;
        ifc.clr_overflow = 1'b0;
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while ((mq.size() != 0 || m_send) && i < 3000) begin
            step(1'b0, 8'h00, 1'b0);
            i++;
        end
        chk(tag, {ifc.empty, ifc.send}, 2'b10);
    endtask

    task automatic wait_send(input logic v, input string tag);
        int i = 0;
        while (ifc.send !== v && i < 50) begin
            step(1'b0, 8'h00, 1'b0);
            i++;
        end
        chk(tag, ifc.send, v);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        chk({tag, "_send"}, ifc.send, 1'b0);
        chk({tag, "_busy"}, ifc.busy, 1'b0);
        chk({tag, "_count"}, ifc.count, 0);
        chk({tag, "_empty"}, ifc.empty, 1'b1);
        chk({tag, "_full"}, ifc.full, 1'b0);
        chk({tag, "_ovf"}, ifc.overflow, 1'b0);
        chk({tag, "_char"}, ifc.char_in, 8'h00);
        mq.delete();
        m_send        = 1'b0;
        m_ov          = 1'b0;
        m_char        = 8'h00;
        prev_send_obs = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        int s0;
        ifc.wr_en        = 1'b0;
        ifc.wr_data      = 8'h00;
        ifc.clr_overflow = 1'b0;
        #1;
        async_reset("reset");

        // 1: single byte, two-edge latency, one send pulse.
        r0 = dut_rises;
        step(1'b1, 8'h41, 1'b0);
        chk("t1_count_after_wr", ifc.count, 1);
        chk("t1_send_not_yet", ifc.send, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_send_edge2", ifc.send, 1'b1);
        chk("t1_char", ifc.char_in, 8'h41);
        repeat (15) step(1'b0, 8'h00, 1'b0);
        chk("t1_one_pulse", dut_rises - r0, 1);

        // 2: fill to full while sent holds pops off, then drop the 17th.
        uart_force = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        chk("t2_full", ifc.full, 1'b1);
        chk("t2_count16", ifc.count, 16);
        step(1'b1, 8'hFF, 1'b0);
        chk("t2_overflow", ifc.overflow, 1'b1);
        chk("t2_count_still16", ifc.count, 16);

        // 6: clear vs. concurrent drop.
        step(1'b0, 8'h00, 1'b1);
        chk("t6_plain_clear", ifc.overflow, 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        chk("t6_drop_wins", ifc.overflow, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("t6_clear_next", ifc.overflow, 1'b0);

        // 2 (cont.): drain order 00..0F.
        s0 = seen.size();
        uart_force = 1'b0;
        drain("t2_drain_done");
        chk("t2_drained_cnt", seen.size() - s0, 16);
        for (int i = 0; i < 16; i++) chk("t2_order", seen[s0 + i], 8'(i));

        // 3: write and pop in the same cycle at count 5, then random traffic through wrap.
        uart_force = 1'b1;
        repeat (5) step(1'b1, 8'($urandom), 1'b0);
        chk("t3_count5_pre", ifc.count, 5);
        uart_force = 1'b0;
        step(1'b1, 8'($urandom), 1'b0);
        chk("t3_same_cycle_count", ifc.count, 5);
        chk("t3_popped", ifc.send, 1'b1);
        s0 = seen.size();
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 4) == 0, 8'($urandom), $urandom_range(0, 30) == 0);
        drain("t3_drain_done");
        chk("t3_wrapped", seen.size() - s0 >= 40, 1'b1);

        // 4: sent held high after send falls blocks the next pop.
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        wait_send(1'b1, "t4_first_send");
        chk("t4_first_char", ifc.char_in, 8'hA1);
        uart_force = 1'b1;
        wait_send(1'b0, "t4_send_fell");
        repeat (4) begin
            step(1'b0, 8'h00, 1'b0);
            chk("t4_no_pop", ifc.send, 1'b0);
        end
        chk("t4_count_held", ifc.count, 1);
        uart_force = 1'b0;
        wait_send(1'b1, "t4_next_send");
        chk("t4_next_char", ifc.char_in, 8'hA2);
        drain("t4_drain_done");

        // 5: reset mid-SEND with three bytes queued.
        uart_force = 1'b1;
        repeat (4) step(1'b1, 8'($urandom), 1'b0);
        uart_force = 1'b0;
        wait_send(1'b1, "t5_in_send");
        chk("t5_count3", ifc.count, 3);
        async_reset("t5_rst");
        r0 = dut_rises;
        repeat (20) step(1'b0, 8'h00, 1'b0);
        chk("t5_no_send_after", dut_rises - r0, 0);
        step(1'b1, 8'h5A, 1'b0);
        drain("t5_drain_done");
        chk("t5_new_byte", seen[seen.size() - 1], 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
